// File: rtl/proto_clone_engine.sv
`default_nettype none
// ============================================================================
// Module   : proto_clone_engine
// Brief    : Prototype bank with mask-merge cloning and a unique instance ID
//            stamped on each instance, emitted on a valid/ready output stream.
// Revision : 1.0 - initial release
// ============================================================================
module proto_clone_engine #(
    parameter  int NUM_PROTOS = 8,
    parameter  int DATA_W     = 32,
    parameter  int ID_W       = 8,
    localparam int SLOT_W     = $clog2(NUM_PROTOS)
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              ld_valid,
    input  logic [SLOT_W-1:0] ld_slot,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              clr,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SLOT_W-1:0] req_slot,
    input  logic [DATA_W-1:0] req_mask,
    input  logic [DATA_W-1:0] req_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ID_W-1:0]   out_id,
    output logic [SLOT_W-1:0] out_slot,
    output logic              out_err,
    output logic [15:0]       clone_cnt
);

    localparam logic [15:0] c_cnt_max = 16'hFFFF;

    logic [DATA_W-1:0]     r_proto [NUM_PROTOS];
    logic [NUM_PROTOS-1:0] r_slot_vld;
    logic [ID_W-1:0]       r_next_id;

    logic                  r_out_valid;
    logic [DATA_W-1:0]     r_out_data;
    logic [ID_W-1:0]       r_out_id;
    logic [SLOT_W-1:0]     r_out_slot;
    logic                  r_out_err;
    logic [15:0]           r_clone_cnt;

    logic                  w_accept;
    logic                  w_out_fire;
    logic [DATA_W-1:0]     w_src;
    logic                  w_src_vld;
    logic [DATA_W-1:0]     w_merged;
    logic [NUM_PROTOS-1:0] w_ld_onehot;
    logic [NUM_PROTOS-1:0] w_slot_vld_nxt;

    assign req_ready  = !r_out_valid | out_ready;
    assign w_accept   = req_valid & req_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Reads use the pre-edge bank, so same-cycle loads/clr are seen one cycle later.
    assign w_src     = r_proto[req_slot];
    assign w_src_vld = r_slot_vld[req_slot];
    assign w_merged  = w_src_vld ? ((w_src & ~req_mask) | (req_data & req_mask)) : '0;

    assign w_ld_onehot    = ld_valid ? (NUM_PROTOS'(1) << ld_slot) : '0;
    assign w_slot_vld_nxt = (clr ? '0 : r_slot_vld) | w_ld_onehot;

    always_ff @(posedge clk) begin
        if (ld_valid) begin
            r_proto[ld_slot] <= ld_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_slot_vld <= '0;
        end else begin
            r_slot_vld <= w_slot_vld_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_id    <= '0;
            r_out_slot  <= '0;
            r_out_err   <= 1'b0;
            r_next_id   <= '0;
            r_clone_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_merged;
                r_out_id    <= r_next_id;
                r_out_slot  <= req_slot;
                r_out_err   <= !w_src_vld;
                r_next_id   <= r_next_id + 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_out_fire && (r_clone_cnt != c_cnt_max)) begin
                r_clone_cnt <= r_clone_cnt + 16'd1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_id    = r_out_id;
    assign out_slot  = r_out_slot;
    assign out_err   = r_out_err;
    assign clone_cnt = r_clone_cnt;

endmodule
`default_nettype wire

// File: tb/tb_proto_clone_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_proto_clone_engine
// Brief    : Randomized and directed bench for proto_clone_engine against a
//            behavioural model of the prototype bank and output stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proto_clone_engine;

    localparam int NP = 8;
    localparam int DW = 32;
    localparam int IW = 8;
    localparam int SW = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ld_valid;
    logic [SW-1:0] ld_slot;
    logic [DW-1:0] ld_data;
    logic          clr;
    logic          req_valid;
    logic          req_ready;
    logic [SW-1:0] req_slot;
    logic [DW-1:0] req_mask;
    logic [DW-1:0] req_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [IW-1:0] out_id;
    logic [SW-1:0] out_slot;
    logic          out_err;
    logic [15:0]   clone_cnt;

    int n_checks;
    int n_fail;

    // Reference model state
    logic [DW-1:0] m_proto [NP];
    logic [NP-1:0] m_vld;
    logic [IW-1:0] m_id;
    logic          m_ov;
    logic [DW-1:0] m_data;
    logic [IW-1:0] m_oid;
    logic [SW-1:0] m_slot;
    logic          m_err;
    logic [15:0]   m_cnt;

    proto_clone_engine #(
        .NUM_PROTOS (NP),
        .DATA_W     (DW),
        .ID_W       (IW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_valid  (ld_valid),
        .ld_slot   (ld_slot),
        .ld_data   (ld_data),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_slot  (req_slot),
        .req_mask  (req_mask),
        .req_data  (req_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_slot  (out_slot),
        .out_err   (out_err),
        .clone_cnt (clone_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vld  = '0;
        m_id   = '0;
        m_ov   = 1'b0;
        m_data = '0;
        m_oid  = '0;
        m_slot = '0;
        m_err  = 1'b0;
        m_cnt  = '0;
    endtask

    task automatic check_outputs();
        chk("out_valid", out_valid, m_ov);
        chk("out_data",  out_data,  m_data);
        chk("out_id",    out_id,    m_oid);
        chk("out_slot",  out_slot,  m_slot);
        chk("out_err",   out_err,   m_err);
        chk("clone_cnt", clone_cnt, m_cnt);
        chk("req_ready", req_ready, !m_ov || out_ready);
    endtask

    // Advance the model across the coming rising edge using the current inputs.
    task automatic model_update();
        logic acc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = req_valid && (!m_ov || out_ready);
        if (m_ov && out_ready && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        if (acc) begin
            m_ov   = 1'b1;
            m_slot = req_slot;
            m_oid  = m_id;
            m_id   = m_id + 8'd1;
            if (m_vld[req_slot]) begin
                m_err  = 1'b0;
                m_data = (m_proto[req_slot] & ~req_mask) | (req_data & req_mask);
            end else begin
                m_err  = 1'b1;
                m_data = '0;
            end
        end else if (out_ready) begin
            m_ov = 1'b0;
        end
        if (clr) m_vld = '0;
        if (ld_valid) begin
            m_proto[ld_slot] = ld_data;
            m_vld[ld_slot]   = 1'b1;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ld_valid  = 1'b0;
        ld_slot   = '0;
        ld_data   = '0;
        clr       = 1'b0;
        req_valid = 1'b0;
        req_slot  = '0;
        req_mask  = '0;
        req_data  = '0;
        out_ready = 1'b1;
    endtask

    task automatic request(input logic [SW-1:0] s, input logic [DW-1:0] mk, input logic [DW-1:0] d);
        req_valid = 1'b1;
        req_slot  = s;
        req_mask  = mk;
        req_data  = d;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle();
        rst_n = 1'b0;
        model_reset();
        repeat (3) cycle();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_id",    out_id,    0);
        chk("rst_clone_cnt", clone_cnt, 0);
        chk("rst_req_ready", req_ready, 1);
        rst_n = 1'b1;

        // Empty slot produces an error instance carrying ID 0
        request(3'd3, $urandom, $urandom);
        cycle();
        idle();
        chk("empty_valid", out_valid, 1);
        chk("empty_err",   out_err,   1);
        chk("empty_data",  out_data,  0);
        chk("empty_id",    out_id,    0);

        // Load then merge
        ld_valid = 1'b1; ld_slot = 3'd2; ld_data = 32'hA5A5_0000;
        cycle();
        ld_valid = 1'b0;
        request(3'd2, 32'h0000_FFFF, 32'h1234_5678);
        cycle();
        idle();
        chk("merge_data", out_data, 32'hA5A5_5678);
        chk("merge_slot", out_slot, 2);
        chk("merge_err",  out_err,  0);
        chk("merge_id",   out_id,   1);

        // Same-cycle load and clone reads the old prototype
        ld_valid = 1'b1; ld_slot = 3'd1; ld_data = 32'h7;
        cycle();
        ld_data = 32'h1;
        request(3'd1, 32'h0, $urandom);
        cycle();
        ld_valid = 1'b0;
        chk("rbw_old", out_data, 32'h7);
        cycle();
        idle();
        chk("rbw_new", out_data, 32'h1);

        // Back-pressure hold, then gap-free IDs
        request(3'd2, 32'h0, $urandom);
        cycle();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_slot = SW'($urandom_range(NP - 1));
            cycle();
            chk("hold_ready", req_ready, 0);
            chk("hold_valid", out_valid, 1);
            chk("hold_id",    out_id,    4);
            chk("hold_data",  out_data,  32'hA5A5_0000);
        end
        out_ready = 1'b1;
        req_slot  = 3'd2;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("stream_id", out_id, 5 + i);
        end
        idle();
        cycle();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            ld_valid  = ($urandom_range(99) < 30);
            ld_slot   = SW'($urandom_range(NP - 1));
            ld_data   = $urandom;
            clr       = ($urandom_range(99) < 4);
            req_valid = ($urandom_range(99) < 70);
            req_slot  = SW'($urandom_range(NP - 1));
            req_mask  = $urandom;
            req_data  = $urandom;
            out_ready = ($urandom_range(99) < 70);
            cycle();
        end
        idle();
        cycle();

        // Clear invalidates every loaded slot
        for (int s = 0; s < NP; s++) begin
            ld_valid = 1'b1; ld_slot = SW'(s); ld_data = $urandom;
            cycle();
        end
        idle();
        clr = 1'b1;
        cycle();
        clr = 1'b0;
        request(3'd5, $urandom, $urandom);
        cycle();
        idle();
        chk("clr_err",  out_err,  1);
        chk("clr_data", out_data, 0);

        // Asynchronous reset while an instance is pending
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_cnt",   clone_cnt, 0);
        cycle();
        cycle();
        rst_n = 1'b1;

        // ID wrap after 257 instances, then counter saturation
        ld_valid = 1'b1; ld_slot = 3'd0; ld_data = $urandom;
        cycle();
        ld_valid = 1'b0;
        for (int n = 1; n <= 65545; n++) begin
            request(SW'($urandom_range(NP - 1)), $urandom, $urandom);
            cycle();
            if (n == 257) chk("id_wrap", out_id, 0);
        end
        chk("cnt_sat", clone_cnt, 16'hFFFF);
        idle();
        repeat (3) cycle();
        chk("cnt_sat_hold", clone_cnt, 16'hFFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
